a23_uart_dce: RTL and testbench
===============================

A23_UART_DCE -- requirements
Module: a23_uart_dce

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk_i cycles per serial bit; legal range 4..65535, even values only.
REQ-002 SHALL have port clk_i  input  1  system clock; all flops rising-edge.
REQ-003 SHALL have port rstn_i  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port dte_txd_i  input  1  serial data driven by the DTE; asynchronous to clk_i.
REQ-005 SHALL have port dte_rxd_o  output  1  serial data driven to the DTE.
REQ-006 SHALL have port tx_dat_i  input  8  byte to send to the DTE.
REQ-007 SHALL have port tx_valid_i  input  1  tx_dat_i valid.
REQ-008 SHALL have port tx_ready_o  output  1  transmitter can accept a byte.
REQ-009 SHALL have port rx_dat_o  output  8  byte received from the DTE.
REQ-010 SHALL have port rx_valid_o  output  1  rx_dat_o holds an unconsumed byte.
REQ-011 SHALL have port rx_ready_i  input  1  consumer takes rx_dat_o.
REQ-012 SHALL have port rx_overrun_o  output  1  one-cycle pulse; received byte dropped.
REQ-013 SHALL have port rx_frame_err_o  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-014 SHALL use 8N1 framing, LSB first: start bit 0, 8 data bits, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-015 TX FSM SHALL have states IDLE, START, DATA, STOP; tx_ready_o=1 only in IDLE.
REQ-016 TX SHALL accept a byte on the edge where tx_valid_i && tx_ready_o; byte latched; FSM moves to START and dte_rxd_o=0 from the next cycle.
REQ-017 TX SHALL drive dte_rxd_o from a flop (glitch-free); dte_rxd_o=1 in IDLE and STOP.
REQ-018 TX SHALL stay in STOP CLKS_PER_BIT cycles, then return to IDLE; total frame 10*CLKS_PER_BIT cycles; back-to-back bytes accepted in the IDLE cycle produce no extra idle bits beyond that cycle.
REQ-019 tx_dat_i changes while TX is busy SHALL NOT affect the frame in flight.
REQ-020 RX SHALL pass dte_txd_i through a 2-flop synchronizer reset to 1; all RX decisions use the synchronized value.
REQ-021 RX FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-022 IDLE->START on synchronized line = 0; START samples at CLKS_PER_BIT/2 cycles after entry: 0 -> DATA, 1 -> IDLE (glitch rejected, no output).
REQ-023 DATA SHALL sample every CLKS_PER_BIT cycles after the start mid-sample, 8 samples shifted LSB first, then STOP.
REQ-024 STOP mid-sample 1 -> byte delivered (REQ-025), FSM -> IDLE; 0 -> byte discarded, rx_frame_err_o pulses 1 cycle, FSM -> WAIT_HIGH.
REQ-025 Delivery SHALL occur on the cycle after the stop mid-sample: if rx_valid_o=0, or rx_valid_o=1 and rx_ready_i=1 that cycle, rx_dat_o loads new byte and rx_valid_o=1; else rx_dat_o unchanged, rx_valid_o stays 1, rx_overrun_o pulses 1 cycle.
REQ-026 rx_valid_o SHALL clear on the edge where rx_valid_o && rx_ready_i and no delivery coincides; rx_ready_i with rx_valid_o=0 has no effect.
REQ-027 WAIT_HIGH SHALL remain until synchronized line = 1, then -> IDLE (break conditions yield one frame error only).
REQ-028 TX and RX SHALL operate fully independently and concurrently (full duplex).
REQ-029 Bit counters SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload, never wrap, between bits.

Reset
REQ-030 On rstn_i low: dte_rxd_o=1, tx_ready_o=1 (after release), rx_dat_o=0, rx_valid_o=0, rx_overrun_o=0, rx_frame_err_o=0, both FSMs IDLE, synchronizer=1, counters 0.
REQ-031 Reset mid-frame SHALL abort both directions immediately; partial RX byte never delivered; dte_rxd_o returns to 1 asynchronously.

Verification
REQ-032 TX: CLKS_PER_BIT=16, send 0xA5 -> dte_rxd_o = 0,1,0,1,0,0,1,0,1,1 each 16 cycles; tx_ready_o low for 160 cycles.
REQ-033 RX loopback: dte_rxd_o tied to dte_txd_i, send 0x00,0xFF,0x3C back-to-back with rx_ready_i=1 -> rx_dat_o 0x00,0xFF,0x3C, no error pulses.
REQ-034 Overrun: rx_ready_i=0, DTE sends 0x11 then 0x22 -> rx_dat_o=0x11, rx_valid_o=1, one rx_overrun_o pulse; then rx_ready_i=1 for one cycle -> rx_valid_o=0.
REQ-035 Framing/glitch: 4-cycle low pulse on dte_txd_i -> no output; frame 0x55 with stop=0 then line held low 40 cycles -> exactly one rx_frame_err_o, rx_valid_o stays 0.
REQ-036 Reset mid-operation: assert rstn_i low during DATA bit 3 of both TX and RX -> all outputs at reset values; next full 0x7E frame received correctly.

Source files
------------

// File: rtl/a23_uart_dce_if.sv
// Parallel-side handshake bundle of the UART DCE: TX byte stream in,
// RX byte stream out plus the RX error strobes.
interface a23_uart_dce_if;
    logic [7:0] tx_dat_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_dat_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       rx_overrun_o;
    logic       rx_frame_err_o;

    // UART side
    modport slave (
        input  tx_dat_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_dat_o, rx_valid_o, rx_overrun_o, rx_frame_err_o
    );

    // Byte producer / consumer side
    modport master (
        output tx_dat_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_dat_o, rx_valid_o, rx_overrun_o, rx_frame_err_o
    );
endinterface

// File: rtl/a23_uart_dce.sv
// Full-duplex 8N1 UART, DCE side. TX serialises bytes onto dte_rxd_o,
// RX deserialises dte_txd_i with mid-bit sampling, a one-byte holding
// register, overrun and framing-error strobes.
module a23_uart_dce #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             dte_txd_i,
    output logic             dte_rxd_o,
    a23_uart_dce_if.slave    bus
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // TX state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) tx_state <= TX_IDLE;
        else         tx_state <= tx_state_nxt;
    end

    // TX next state: each non-idle state lasts whole bit periods
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (bus.tx_valid_i)                tx_state_nxt = TX_START;
            TX_START: if (tx_bit_end)                    tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7)  tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_bit_end)                    tx_state_nxt = TX_IDLE;
            default:                                     tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX outputs: ready only while idle
    always_comb begin
        bus.tx_ready_o = (tx_state == TX_IDLE);
    end

    // TX datapath: bit timer, byte shifter and the registered line driver
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            dte_rxd_o <= 1'b1;
        end else begin
            // timer reloads at every bit boundary and rests at 0 when idle
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (bus.tx_valid_i) begin
                        tx_sh     <= bus.tx_dat_i;
                        tx_bit    <= '0;
                        dte_rxd_o <= 1'b0;
                    end else begin
                        dte_rxd_o <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) dte_rxd_o <= tx_sh[0];
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            dte_rxd_o <= 1'b1;
                        end else begin
                            tx_bit    <= tx_bit + 1'b1;
                            tx_sh     <= {1'b0, tx_sh[7:1]};
                            dte_rxd_o <= tx_sh[1];
                        end
                    end
                end
                default: dte_rxd_o <= 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    rx_state_t     rx_state, rx_state_nxt;
    logic [1:0]    rx_sync;
    logic          rx_line;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_tick;
    logic          rx_deliver;
    logic          rx_take;
    logic          rx_drop;

    assign rx_line = rx_sync[1];
    // Start waits half a bit to land mid-bit; later samples are a full bit apart
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

    // Line synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rx_sync <= 2'b11;
        else         rx_sync <= {rx_sync[0], dte_txd_i};
    end

    // RX state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_nxt;
    end

    // RX next state
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_line)                   rx_state_nxt = RX_START;
            RX_START:     if (rx_tick)                    rx_state_nxt = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_bit == 3'd7)  rx_state_nxt = RX_STOP;
            RX_STOP:      if (rx_tick)                    rx_state_nxt = rx_line ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_line)                    rx_state_nxt = RX_IDLE;
            default:                                      rx_state_nxt = RX_IDLE;
        endcase
    end

    // RX delivery decision: load if the holding register is free this cycle
    always_comb begin
        rx_take = rx_deliver && (!bus.rx_valid_o || bus.rx_ready_i);
        rx_drop = rx_deliver && bus.rx_valid_o && !bus.rx_ready_i;
    end

    // RX datapath: sample timer, shifter, holding register and strobes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_cnt             <= '0;
            rx_bit             <= '0;
            rx_sh              <= '0;
            rx_deliver         <= 1'b0;
            bus.rx_dat_o       <= '0;
            bus.rx_valid_o     <= 1'b0;
            bus.rx_overrun_o   <= 1'b0;
            bus.rx_frame_err_o <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || rx_tick) rx_cnt <= '0;
            else                                                            rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START && rx_tick) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_sh  <= {rx_line, rx_sh[7:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            rx_deliver         <= (rx_state == RX_STOP) && rx_tick && rx_line;
            bus.rx_frame_err_o <= (rx_state == RX_STOP) && rx_tick && !rx_line;
            bus.rx_overrun_o   <= rx_drop;
            if (rx_take) begin
                bus.rx_dat_o   <= rx_sh;
                bus.rx_valid_o <= 1'b1;
            end else if (bus.rx_valid_o && bus.rx_ready_i) begin
                bus.rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_a23_uart_dce.sv
// Scoreboard bench for a23_uart_dce at CLKS_PER_BIT=16.
module tb_a23_uart_dce;

    localparam int CPB = 16;

    logic clk;
    logic rstn;
    logic tb_txd;
    logic loop_en;
    logic dte_txd;
    logic dte_rxd;

    int n_chk  = 0;
    int n_fail = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;

    logic [7:0] rx_q[$];
    logic       tx_q[$];

    a23_uart_dce_if bus ();

    a23_uart_dce #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .dte_txd_i (dte_txd),
        .dte_rxd_o (dte_rxd),
        .bus       (bus)
    );

    assign dte_txd = loop_en ? dte_rxd : tb_txd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // DTE-side serialiser driving dte_txd_i
    task automatic dte_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tb_txd = f[i];
            idle(CPB);
        end
    endtask

    // Present one byte to TX and hold it until accepted
    task automatic tx_send(input logic [7:0] b);
        int n;
        n = 0;
        bus.tx_dat_i   = b;
        bus.tx_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.tx_ready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("tx_accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic wait_q(input int max);
        int n;
        n = 0;
        while (rx_q.size() != 0 && n < max) begin
            idle(1);
            n++;
        end
        chk("rx_q_drain", 32'(rx_q.size()), 32'd0);
    endtask

    // RX monitor: pop the scoreboard on each consumed byte, count strobes
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.rx_valid_o && bus.rx_ready_i) begin
                if (rx_q.size() == 0) begin
                    chk("rx_extra", {24'd0, bus.rx_dat_o}, 32'hDEAD);
                end else begin
                    logic [7:0] e;
                    e = rx_q.pop_front();
                    chk("rx_dat", {24'd0, bus.rx_dat_o}, {24'd0, e});
                end
            end
            if (bus.rx_overrun_o)   ovr_cnt++;
            if (bus.rx_frame_err_o) ferr_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int o0;
        int f0;
        logic [7:0] b;
        logic [9:0] pf;
        logic [7:0] lb[3];

        rstn           = 1'b0;
        loop_en        = 1'b0;
        tb_txd         = 1'b1;
        bus.tx_dat_i   = '0;
        bus.tx_valid_i = 1'b0;
        bus.rx_ready_i = 1'b0;

        // reset state
        idle(3);
        chk("rst_rxd", {31'd0, dte_rxd}, 32'd1);
        chk("rst_rx_dat", {24'd0, bus.rx_dat_o}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        chk("rst_overrun", {31'd0, bus.rx_overrun_o}, 32'd0);
        chk("rst_frame_err", {31'd0, bus.rx_frame_err_o}, 32'd0);
        rstn = 1'b1;
        idle(2);
        chk("rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);

        // TX frame of 0xA5, bit-level scoreboard sampled mid-bit
        b = 8'hA5;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
        tx_q.push_back(1'b1);
        bus.tx_dat_i   = b;
        bus.tx_valid_i = 1'b1;
        idle(1);
        bus.tx_valid_i = 1'b0;
        bus.tx_dat_i   = 8'hFF;          // must not disturb the frame in flight
        low_cnt = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            if (!bus.tx_ready_o) low_cnt++;
            if (c % CPB == CPB / 2) chk("tx_bit", {31'd0, dte_rxd}, {31'd0, tx_q.pop_front()});
        end
        @(negedge clk);
        chk("tx_busy_cycles", 32'(low_cnt), 32'd160);
        chk("tx_ready_after", {31'd0, bus.tx_ready_o}, 32'd1);
        chk("tx_line_idle", {31'd0, dte_rxd}, 32'd1);
        @(posedge clk);
        #1;

        // loopback, back-to-back bytes
        loop_en = 1'b1;
        bus.rx_ready_i = 1'b1;
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            rx_q.push_back(lb[i]);
            tx_send(lb[i]);
        end
        wait_q(600);
        chk("loop_overrun", 32'(ovr_cnt - o0), 32'd0);
        chk("loop_frame_err", 32'(ferr_cnt - f0), 32'd0);
        idle(20);
        loop_en = 1'b0;

        // overrun: second byte dropped while first unconsumed
        bus.rx_ready_i = 1'b0;
        o0 = ovr_cnt;
        rx_q.push_back(8'h11);
        dte_send(8'h11, 1'b1);
        dte_send(8'h22, 1'b1);
        idle(30);
        chk("ovr_rx_dat", {24'd0, bus.rx_dat_o}, 32'h11);
        chk("ovr_rx_valid", {31'd0, bus.rx_valid_o}, 32'd1);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        bus.rx_ready_i = 1'b1;
        idle(1);
        bus.rx_ready_i = 1'b0;
        @(negedge clk);
        chk("ovr_valid_clear", {31'd0, bus.rx_valid_o}, 32'd0);
        chk("ovr_q_empty", 32'(rx_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // glitch rejection
        bus.rx_ready_i = 1'b1;
        f0 = ferr_cnt;
        tb_txd = 1'b0;
        idle(4);
        tb_txd = 1'b1;
        idle(40);
        chk("glitch_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // framing error followed by a held-low line
        dte_send(8'h55, 1'b0);
        idle(40);
        tb_txd = 1'b1;
        idle(40);
        chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("ferr_valid", {31'd0, bus.rx_valid_o}, 32'd0);

        // reset in the middle of data bit 3 on both directions
        pf = {1'b1, 8'h5A, 1'b0};
        bus.tx_dat_i   = 8'hC3;
        bus.tx_valid_i = 1'b1;
        for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
            tb_txd = pf[c / CPB];
            idle(1);
            bus.tx_valid_i = 1'b0;
        end
        chk("mid_tx_bit3", {31'd0, dte_rxd}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rxd", {31'd0, dte_rxd}, 32'd1);
        chk("mid_rst_rx_dat", {24'd0, bus.rx_dat_o}, 32'd0);
        chk("mid_rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        chk("mid_rst_overrun", {31'd0, bus.rx_overrun_o}, 32'd0);
        chk("mid_rst_frame_err", {31'd0, bus.rx_frame_err_o}, 32'd0);
        tb_txd = 1'b1;
        idle(3);
        rstn = 1'b1;
        idle(2);
        chk("post_rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        chk("post_rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        rx_q.push_back(8'h7E);
        dte_send(8'h7E, 1'b1);
        wait_q(200);
        chk("post_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("post_rst_ovr", 32'(ovr_cnt - o0), 32'd0);
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
